// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response channel between the fetch stage and instruction memory.
// The master issues byte addresses; the slave returns words in order.
interface imem_fetch_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_fault;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_fault
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction memory answering in-order fetches after LATENCY cycles.
// Optional IMEM_PARITY_EN adds a per-word even-parity bit and ld_perr_inject.
module imem_fetch_responder #(
    parameter int DEPTH_WORDS     = 256,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    imem_fetch_responder_if.slave  bus,
    input  logic                   ld_en,
    input  logic [31:0]            ld_addr,
`ifdef IMEM_PARITY_EN
    input  logic                   ld_perr_inject,
`endif
    input  logic [31:0]            ld_data
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [2:0]  MAXO  = 3'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [AW-1:0] w_ld_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_perr;
    logic          w_bad;
    logic [31:0]   w_in_i;
    logic          w_acc;
    logic          w_cons;
    logic          w_unused_ld;

    logic [2:0]    r_outst;

    logic          w_push_v;
    logic [31:0]   w_push_i;
    logic          w_push_f;

    logic [31:0]   r_fi [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] r_ff;
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [2:0]    r_fcnt;
    logic [PW-1:0] w_wp_nx;
    logic [PW-1:0] w_rp_nx;

    assign w_ld_idx    = ld_addr[AW+1:2];
    assign w_rd_idx    = bus.req_addr[AW+1:2];
    assign w_unused_ld = ^{ld_addr[31:AW+2], ld_addr[1:0]};

    // Loads ignore reset so boot logic can preload while the core is held.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_mem[w_ld_idx] <= ld_data;
        end
    end

`ifdef IMEM_PARITY_EN
    logic [DEPTH_WORDS-1:0] r_par;

    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_par[w_ld_idx] <= (^ld_data) ^ ld_perr_inject;
        end
    end

    assign w_perr = ^{r_mem[w_rd_idx], r_par[w_rd_idx]};
`else
    assign w_perr = 1'b0;
`endif

    assign w_bad = (bus.req_addr[1:0] != 2'b00)
                || (bus.req_addr >= LIMIT)
                || w_perr;
    assign w_in_i = w_bad ? NOP : r_mem[w_rd_idx];

    assign bus.req_ready = reset_n && (r_outst < MAXO);
    assign w_acc  = bus.req_valid && bus.req_ready;
    assign w_cons = bus.rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_outst <= '0;
        end else begin
            r_outst <= r_outst + {2'b00, w_acc} - {2'b00, w_cons};
        end
    end

    // The word is captured at the accept edge; the last stage lands in the buffer.
    generate
        if (LATENCY == 1) begin : g_l1
            assign w_push_v = w_acc;
            assign w_push_i = w_in_i;
            assign w_push_f = w_bad;
        end else begin : g_pipe
            logic [LATENCY-2:0] r_pv;
            logic [LATENCY-2:0] r_pf;
            logic [31:0]        r_pi [LATENCY-1];

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_pv <= '0;
                end else begin
                    r_pv[0] <= w_acc;
                    for (int k = 1; k < LATENCY - 1; k++) begin
                        r_pv[k] <= r_pv[k-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                r_pi[0] <= w_in_i;
                r_pf[0] <= w_bad;
                for (int k = 1; k < LATENCY - 1; k++) begin
                    r_pi[k] <= r_pi[k-1];
                    r_pf[k] <= r_pf[k-1];
                end
            end

            assign w_push_v = r_pv[LATENCY-2];
            assign w_push_i = r_pi[LATENCY-2];
            assign w_push_f = r_pf[LATENCY-2];
        end
    endgenerate

    assign w_wp_nx = (r_wp == LAST) ? '0 : r_wp + PW'(1);
    assign w_rp_nx = (r_rp == LAST) ? '0 : r_rp + PW'(1);

    // Outstanding limit guarantees the buffer never overflows.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_push_v) begin
                r_wp <= w_wp_nx;
            end
            if (w_cons) begin
                r_rp <= w_rp_nx;
            end
            r_fcnt <= r_fcnt + {2'b00, w_push_v} - {2'b00, w_cons};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_v) begin
            r_fi[r_wp] <= w_push_i;
            r_ff[r_wp] <= w_push_f;
        end
    end

    assign bus.rsp_valid = (r_fcnt != 3'd0);
    assign bus.rsp_instr = bus.rsp_valid ? r_fi[r_rp] : 32'h0;
    assign bus.rsp_fault = bus.rsp_valid && r_ff[r_rp];

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench with an in-order scoreboard for imem_fetch_responder.
// Build with IMEM_PARITY_EN defined to also exercise the parity fault path.
module tb_imem_fetch_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ld_perr_inject = 1'b0;

    imem_fetch_responder_if bus();

    imem_fetch_responder #(
        .DEPTH_WORDS(256),
        .LATENCY(2),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .ld_en(ld_en),
        .ld_addr(ld_addr),
`ifdef IMEM_PARITY_EN
        .ld_perr_inject(ld_perr_inject),
`endif
        .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [32:0] sb_q [$];
    logic [31:0] mdl [256];
    logic        mdl_bad [256];

    logic        held = 1'b0;
    logic [32:0] held_v = '0;

    task automatic check(string tag, logic [32:0] obs, logic [32:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] expect_of(logic [31:0] a);
        if (a[1:0] != 2'b00 || a >= 32'd1024 || mdl_bad[a[9:2]])
            return {1'b1, 32'h00000013};
        return {1'b0, mdl[a[9:2]]};
    endfunction

    task automatic load(logic [31:0] a, logic [31:0] d, logic inj);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        ld_perr_inject = inj;
        @(posedge clk); #1;
        ld_en = 1'b0;
        ld_perr_inject = 1'b0;
        mdl[a[9:2]] = d;
        mdl_bad[a[9:2]] = inj;
    endtask

    task automatic issue(logic [31:0] a);
        logic ok;
        ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr = a;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                sb_q.push_back(expect_of(a));
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        bus.req_valid = 1'b0;
        check("req_accept", {32'b0, ok}, 33'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain", 33'(sb_q.size()), 33'd0);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", {32'b0, bus.rsp_valid}, 33'd1);
                check("stall_stable", {bus.rsp_fault, bus.rsp_instr}, held_v);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_cmp++;
                assert (sb_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_rsp: got %h want none",
                           {bus.rsp_fault, bus.rsp_instr});
                end
                if (sb_q.size() != 0)
                    check("rsp", {bus.rsp_fault, bus.rsp_instr}, sb_q.pop_front());
            end
            held = bus.rsp_valid && !bus.rsp_ready;
            held_v = {bus.rsp_fault, bus.rsp_instr};
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mdl[i] = '0;
            mdl_bad[i] = 1'b0;
        end
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.rsp_ready = 1'b1;

        // reset
        @(negedge clk);
        check("rst_req_ready", {32'b0, bus.req_ready}, 33'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", {32'b0, bus.req_ready}, 33'd1);
        check("post_rst_rsp_valid", {32'b0, bus.rsp_valid}, 33'd0);
        check("post_rst_rsp", {bus.rsp_fault, bus.rsp_instr}, 33'd0);
        @(posedge clk); #1;

        // program image
        load(32'h0, 32'h00500093, 1'b0);
        load(32'h4, 32'h00A00113, 1'b0);
        load(32'h8, 32'h002081B3, 1'b0);
        load(32'hC, 32'h0000006F, 1'b0);
        load(32'h10, 32'h00000013, 1'b0);
        load(32'h3FC, 32'hCAFEF00D, 1'b0);
        load(32'h420, 32'h12345678, 1'b0);

        // latency
        issue(32'h0);
        check("lat_not_yet", {32'b0, bus.rsp_valid}, 33'd0);
        @(posedge clk); #1;
        check("lat_valid", {32'b0, bus.rsp_valid}, 33'd1);
        check("lat_word", {bus.rsp_fault, bus.rsp_instr}, {1'b0, 32'h00500093});
        drain();

        // back-to-back
        issue(32'h0);
        issue(32'h4);
        issue(32'h8);
        issue(32'hC);
        drain();

        // backpressure
        bus.rsp_ready = 1'b0;
        issue(32'h0);
        issue(32'h4);
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h8;
        repeat (3) begin
            @(negedge clk);
            check("bp_full", {32'b0, bus.req_ready}, 33'd0);
        end
        sb_q.push_back(expect_of(32'h8));
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        check("bp_still_full", {32'b0, bus.req_ready}, 33'd0);
        @(posedge clk); #1;
        check("bp_reopen", {32'b0, bus.req_ready}, 33'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        drain();

        // address faults and boundaries
        issue(32'h6);
        issue(32'h400);
        issue(32'h3FC);
        issue(32'h20);
        drain();

        // load and fetch on the same edge
        ld_en = 1'b1;
        ld_addr = 32'h10;
        ld_data = 32'hDEADBEEF;
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h10;
        @(negedge clk);
        check("same_edge_ready", {32'b0, bus.req_ready}, 33'd1);
        sb_q.push_back(expect_of(32'h10));
        @(posedge clk); #1;
        ld_en = 1'b0;
        bus.req_valid = 1'b0;
        mdl[4] = 32'hDEADBEEF;
        issue(32'h10);
        drain();

        // reset with requests in flight
        bus.rsp_ready = 1'b0;
        issue(32'h0);
        issue(32'h4);
        reset_n = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", {32'b0, bus.rsp_valid}, 33'd0);
        check("mid_rst_ready", {32'b0, bus.req_ready}, 33'd1);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_quiet", {32'b0, bus.rsp_valid}, 33'd0);
        end
        @(posedge clk); #1;
        issue(32'h0);
        drain();

`ifdef IMEM_PARITY_EN
        load(32'h8, 32'h002081B3, 1'b1);
        issue(32'h8);
        issue(32'h4);
        drain();
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
